// File: rtl/mem_stage_if.sv
// MEM stage bundle: EX/MEM register outputs in, branch redirect and MEM/WB register out.
// Latency: n/a (signal bundle only).
// Backpressure: stall travels with the bundle; the EX/MEM side drives it.
//
// Ports (master = EX/MEM side / bench, slave = mem_stage):
//   stall, Zero, ALU_result, Data_2, Jump_address, Branch_address, WriteRegister,
//   PC_4, Jump, BranchEQ, BranchNE, MemRead, MemWrite, MemtoReg, RegWrite -> stage
//   PCSrc, PC_target, Flush, *_out MEM/WB fields, Misaligned_error, Range_error <- stage
interface mem_stage_if #(
  parameter int N = 32
);
  // EX/MEM side
  logic         stall;
  logic         Zero;
  logic [N-1:0] ALU_result;
  logic [N-1:0] Data_2;
  logic [N-1:0] Jump_address;
  logic [N-1:0] Branch_address;
  logic [4:0]   WriteRegister;
  logic [N-1:0] PC_4;
  logic         Jump;
  logic         BranchEQ;
  logic         BranchNE;
  logic         MemRead;
  logic         MemWrite;
  logic         MemtoReg;
  logic         RegWrite;

  // Redirect (combinational)
  logic         PCSrc;
  logic [N-1:0] PC_target;
  logic         Flush;

  // MEM/WB register
  logic [N-1:0] Read_data_out;
  logic [N-1:0] ALU_result_out;
  logic [4:0]   WriteRegister_out;
  logic [N-1:0] PC_4_out;
  logic         MemtoReg_out;
  logic         RegWrite_out;

  // Sticky fault flags
  logic         Misaligned_error;
  logic         Range_error;

  modport master (
    output stall, Zero, ALU_result, Data_2, Jump_address, Branch_address,
           WriteRegister, PC_4, Jump, BranchEQ, BranchNE, MemRead, MemWrite,
           MemtoReg, RegWrite,
    input  PCSrc, PC_target, Flush, Read_data_out, ALU_result_out,
           WriteRegister_out, PC_4_out, MemtoReg_out, RegWrite_out,
           Misaligned_error, Range_error
  );

  modport slave (
    input  stall, Zero, ALU_result, Data_2, Jump_address, Branch_address,
           WriteRegister, PC_4, Jump, BranchEQ, BranchNE, MemRead, MemWrite,
           MemtoReg, RegWrite,
    output PCSrc, PC_target, Flush, Read_data_out, ALU_result_out,
           WriteRegister_out, PC_4_out, MemtoReg_out, RegWrite_out,
           Misaligned_error, Range_error
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump redirect, word data memory, MEM/WB register, sticky faults.
// Latency: redirect is combinational; store commits at posedge; MEM/WB captures at the next negedge.
// Backpressure: stall=1 holds MEM/WB and blocks the store; redirect and fault flags keep running.
//
// Ports:
//   clk   - memory writes and fault flags on posedge, MEM/WB on negedge
//   reset - asynchronous, active-low; clears MEM/WB and flags, masks redirect
//   bus   - mem_stage_if.slave carrying EX/MEM inputs and all stage outputs
module mem_stage #(
  parameter int           N         = 32,
  parameter int           MEM_DEPTH = 256,
  parameter logic [N-1:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam int           AW        = $clog2(MEM_DEPTH);
  localparam logic [N-1:0] WIN_BYTES = N'(4 * MEM_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [N-1:0]  offset;
  logic          in_range;
  logic          aligned;
  logic          access;
  logic          legal;
  logic [AW-1:0] word_idx;

  // The lower-bound compare is needed because offset wraps for addresses below
  // the window and could otherwise alias into it.
  assign offset   = bus.ALU_result - BASE_ADDR;
  assign in_range = (bus.ALU_result >= BASE_ADDR) && (offset < WIN_BYTES);
  assign aligned  = (bus.ALU_result[1:0] == 2'b00);
  assign access   = bus.MemRead | bus.MemWrite;
  assign legal    = access & aligned & in_range;
  assign word_idx = offset[AW+1:2];

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [N-1:0] mem [MEM_DEPTH];
  logic [N-1:0] rd_val;
  logic         mem_we;

  assign rd_val = (bus.MemRead && legal) ? mem[word_idx] : '0;
  assign mem_we = bus.MemWrite & legal & ~bus.stall;

  // Contents survive reset; reset only gates the write so that no store
  // lands while reset is low, and the first write is the first posedge
  // that sees reset high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // array keeps its contents
    end else if (mem_we) begin
      mem[word_idx] <= bus.Data_2;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky fault flags
  // ---------------------------------------------------------------------------
  logic mis_q, mis_d;
  logic rng_q, rng_d;

  // A misaligned access reports only the misalignment, never a range fault.
  always_comb begin
    mis_d = mis_q | (access & ~aligned);
    rng_d = rng_q | (access & aligned & ~in_range);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
      rng_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      rng_q <= rng_d;
    end
  end

  assign bus.Misaligned_error = mis_q;
  assign bus.Range_error      = rng_q;

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic         take;
  logic         pcsrc;
  logic [N-1:0] target;

  always_comb begin
    take   = (bus.BranchEQ & bus.Zero) | (bus.BranchNE & ~bus.Zero);
    pcsrc  = 1'b0;
    target = '0;
    if (reset) begin
      pcsrc = bus.Jump | take;
      // Jump wins over a simultaneously taken branch.
      if (bus.Jump) begin
        target = bus.Jump_address;
      end else if (take) begin
        target = bus.Branch_address;
      end
    end
  end

  assign bus.PCSrc     = pcsrc;
  assign bus.PC_target = target;
  assign bus.Flush     = pcsrc;

  // ---------------------------------------------------------------------------
  // MEM/WB register (negedge). Flush deliberately does not touch it: the
  // redirecting instruction itself still retires.
  // ---------------------------------------------------------------------------
  logic [N-1:0] rd_q,   rd_d;
  logic [N-1:0] alu_q,  alu_d;
  logic [4:0]   wreg_q, wreg_d;
  logic [N-1:0] pc4_q,  pc4_d;
  logic         m2r_q,  m2r_d;
  logic         rw_q,   rw_d;

  always_comb begin
    rd_d   = rd_q;
    alu_d  = alu_q;
    wreg_d = wreg_q;
    pc4_d  = pc4_q;
    m2r_d  = m2r_q;
    rw_d   = rw_q;
    if (!bus.stall) begin
      rd_d   = rd_val;
      alu_d  = bus.ALU_result;
      wreg_d = bus.WriteRegister;
      pc4_d  = bus.PC_4;
      m2r_d  = bus.MemtoReg;
      rw_d   = bus.RegWrite;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      alu_q  <= '0;
      wreg_q <= '0;
      pc4_q  <= '0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      alu_q  <= alu_d;
      wreg_q <= wreg_d;
      pc4_q  <= pc4_d;
      m2r_q  <= m2r_d;
      rw_q   <= rw_d;
    end
  end

  assign bus.Read_data_out     = rd_q;
  assign bus.ALU_result_out    = alu_q;
  assign bus.WriteRegister_out = wreg_q;
  assign bus.PC_4_out          = pc4_q;
  assign bus.MemtoReg_out      = m2r_q;
  assign bus.RegWrite_out      = rw_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes EX/MEM register outputs and resolves branch/jump redirection.
- Performs word-wide data memory access and drives the MEM/WB pipeline register for writeback.
- Contains the data memory array, misalignment/range checking with sticky fault flags, and stall hold of MEM/WB.

Parameters:
N, 32, datapath width
MEM_DEPTH, 256, data memory depth in N-bit words (power of 2)
BASE_ADDR, 32'h1001_0000, byte address of memory word 0

Ports:
clk  input  1  clock; memory writes on posedge, MEM/WB captures on negedge
reset  input  1  reset, asynchronous, active-low
stall  input  1  1 = hold MEM/WB contents and suppress memory write
Zero  input  1  ALU zero flag from EX/MEM
ALU_result  input  N  effective address / ALU value
Data_2  input  N  store data
Jump_address  input  N  jump target
Branch_address  input  N  branch target
WriteRegister  input  5  destination register
PC_4  input  N  PC+4 of this instruction
Jump, BranchEQ, BranchNE, MemRead, MemWrite, MemtoReg, RegWrite  input  1 each  control
PCSrc  output  1  redirect PC this cycle (combinational)
PC_target  output  N  redirect target (combinational)
Flush  output  1  flush IF/ID and ID/EX (combinational, equals PCSrc)
Read_data_out  output  N  MEM/WB: loaded word
ALU_result_out  output  N  MEM/WB: ALU value
WriteRegister_out  output  5  MEM/WB: destination
PC_4_out  output  N  MEM/WB: PC+4
MemtoReg_out, RegWrite_out  output  1 each  MEM/WB control
Misaligned_error  output  1  sticky: access with ALU_result[1:0] != 0
Range_error  output  1  sticky: access outside memory window

Behaviour:
- Reset (async, reset=0):
  - All MEM/WB outputs and both sticky flags go to 0 immediately.
  - PCSrc, PC_target, and Flush are forced to 0 while reset=0.
  - Memory contents are not reset.
- Address decode:
  - offset = ALU_result - BASE_ADDR (N-bit unsigned).
  - In range iff ALU_result >= BASE_ADDR and offset < 4*MEM_DEPTH.
  - Word index = offset[log2(MEM_DEPTH)+1:2].
- Access is legal iff (MemRead | MemWrite), ALU_result[1:0] == 0, and the address is in range.
- Read: combinational from the array when MemRead is 1 and the access is legal; otherwise the read value is 0.
- Write: on posedge clk when MemWrite=1, legal, stall=0, and reset=1. An illegal store writes nothing.
- Faults:
  - Misaligned access (MemRead|MemWrite with ALU_result[1:0] != 0) sets Misaligned_error on the next posedge.
  - Out-of-range aligned access sets Range_error on the next posedge.
  - Both flags stay set until reset. Flags do not stall or flush the pipeline.
- Branch resolution (combinational):
  - take = (BranchEQ & Zero) | (BranchNE & ~Zero).
  - PCSrc = Jump | take.
  - PC_target = Jump ? Jump_address : (take ? Branch_address : 0). Jump has priority if both Jump and take are asserted.
- MEM/WB register (negedge clk):
  - stall=0: capture read value, ALU_result, WriteRegister, PC_4, MemtoReg, and RegWrite.
  - stall=1: all MEM/WB outputs hold.
  - Flush does not affect MEM/WB: the redirecting instruction itself completes.
- Timing: EX/MEM updates on negedge k. The store writes at the following posedge. A load presented at negedge k+1 reads the new value. MEM/WB latency is one negedge after inputs present.
- Reset deasserted mid-cycle: the first write occurs at the first posedge with reset=1.

Test Plan:
- Reset: drive reset=0 with all inputs nonzero -> all MEM/WB outputs, PCSrc, PC_target, Flush, and both flags read 0. Deassert reset, then negedge -> outputs capture the inputs.
- Store/load: SW with ALU_result=0x1001_0010, Data_2=0xDEAD_BEEF; next cycle LW at the same address with MemtoReg=1 and WriteRegister=8 -> after the negedge, Read_data_out=0xDEAD_BEEF, WriteRegister_out=8. Then a load from 0x1001_03FC after storing 0x1234 there -> reads 0x1234 (top word).
- Branch: BranchEQ=1 with Zero=1 and Branch_address=0x0040_0020 -> PCSrc=1, Flush=1, PC_target=0x0040_0020. Same with Zero=0 -> PCSrc=0. BranchNE=1 with Zero=0 -> PCSrc=1. Jump=1 plus a taken branch, Jump_address=0x0040_0100 -> PC_target=0x0040_0100.
- Misaligned: SW to 0x1001_0012 with Data_2=0x5555 -> word 0x1001_0010 unchanged and Misaligned_error=1. Flag stays 1 over 10 further cycles; reset clears it.
- Range: LW from 0x1001_0400 (MEM_DEPTH=256) -> Read_data_out=0 and Range_error=1. Same for 0x0FFF_FFFC. Misaligned_error stays 0 for both.
- Stall: assert stall=1 during SW to 0x1001_0020 with new inputs -> MEM/WB outputs hold previous values and memory is unchanged. Release stall -> write occurs and MEM/WB captures on the next negedge.
